noc_rx_sink: RTL and testbench

Receive-side sink that sits directly downstream of one processor port of the 2x2 mesh. It consumes the 9-bit `pN_recieve_data` flit stream and buffers payload bytes in a first-word-fall-through FIFO toward the processor. It drives that port's bit of `processor_ready_signals` as back-pressure, and counts flits lost to overflow. One instance is placed per processor port, four in total.

---
 rtl/noc_rx_sink.sv | 102 ++++++++++
 tb/tb_noc_rx_sink.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/noc_rx_sink.sv
// Receive-side sink for one mesh processor port: FWFT byte FIFO with
// almost-full back-pressure toward the mesh and a saturating overflow-drop counter.
module noc_rx_sink #(
  parameter int DEPTH = 8,
  parameter int SLACK = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [8:0]               recieve_data,
  output logic                     ready_to_mesh,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               drop_count,
  input  logic                     clear_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   HIGH_C   = (AW+1)'(DEPTH - SLACK);
  localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [7:0]    drop_q, drop_d;
  logic          write_s, drop_s, pop_s, not_empty_s;

  // Event decode and next-state; fullness is judged only on the registered count
  always_comb begin
    not_empty_s = (occ_q != {(AW+1){1'b0}});
    write_s     = recieve_data[8] && (occ_q != FULL_C);
    drop_s      = recieve_data[8] && (occ_q == FULL_C);
    pop_s       = not_empty_s && rd_ready;

    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;

    if (write_s && !pop_s) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop_s && !write_s) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end

    if (write_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Clear wins over a same-cycle drop
    if (clear_drops) begin
      drop_d = 8'h00;
    end else if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'h01;
    end else begin
      drop_d = drop_q;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {(AW+1){1'b0}};
      drop_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (write_s) begin
      mem_q[wr_ptr_q] <= recieve_data[7:0];
    end
  end

  assign rd_valid      = not_empty_s;
  assign rd_data       = not_empty_s ? mem_q[rd_ptr_q] : 8'h00;
  assign ready_to_mesh = (occ_q < HIGH_C);
  assign occupancy     = occ_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_noc_rx_sink.sv
// Self-checking bench for noc_rx_sink: directed scenarios plus a random run
// compared against a queue-based reference model.
module tb_noc_rx_sink;

  localparam int DEPTH = 8;
  localparam int SLACK = 2;
  localparam int OW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [8:0]    recieve_data = 9'h000;
  logic          rd_ready = 1'b0;
  logic          clear_drops = 1'b0;
  logic          ready_to_mesh;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [OW-1:0] occupancy;
  logic [7:0]    drop_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  int m_drops = 0;

  noc_rx_sink #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clock(clock), .reset(reset), .recieve_data(recieve_data),
    .ready_to_mesh(ready_to_mesh), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .occupancy(occupancy), .drop_count(drop_count),
    .clear_drops(clear_drops)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle and advance the reference model across the edge
  task automatic drive(input logic [8:0] d, input logic rdy, input logic clr);
    bit full, pop;
    recieve_data = d;
    rd_ready     = rdy;
    clear_drops  = clr;
    @(posedge clock);
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (d[8] && !full) mq.push_back(d[7:0]);
    if (clr) m_drops = 0;
    else if (d[8] && full && m_drops < 255) m_drops++;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks += 5;
    if (ready_to_mesh !== 1'b1) begin failures++; $display("FAIL reset_ready act=%0b exp=1", ready_to_mesh); end
    if (rd_valid !== 1'b0)      begin failures++; $display("FAIL reset_valid act=%0b exp=0", rd_valid); end
    if (rd_data !== 8'h00)      begin failures++; $display("FAIL reset_data act=%h exp=00", rd_data); end
    if (occupancy !== '0)       begin failures++; $display("FAIL reset_occ act=%0d exp=0", occupancy); end
    if (drop_count !== 8'h00)   begin failures++; $display("FAIL reset_drops act=%0d exp=0", drop_count); end
    reset = 1'b1;
    drive(9'h111, 1'b0, 1'b0);
    drive(9'h122, 1'b0, 1'b0);
    drive(9'h133, 1'b0, 1'b0);
    drive(9'h000, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 4'd3) begin failures++; $display("FAIL prereset_occ act=%0d exp=3", occupancy); end
    #2 reset = 1'b0;
    mq.delete();
    m_drops = 0;
    #1;
    checks += 5;
    if (ready_to_mesh !== 1'b1) begin failures++; $display("FAIL midreset_ready act=%0b exp=1", ready_to_mesh); end
    if (rd_valid !== 1'b0)      begin failures++; $display("FAIL midreset_valid act=%0b exp=0", rd_valid); end
    if (rd_data !== 8'h00)      begin failures++; $display("FAIL midreset_data act=%h exp=00", rd_data); end
    if (occupancy !== '0)       begin failures++; $display("FAIL midreset_occ act=%0d exp=0", occupancy); end
    if (drop_count !== 8'h00)   begin failures++; $display("FAIL midreset_drops act=%0d exp=0", drop_count); end
    #2 reset = 1'b1;
    drive(9'h0AA, 1'b0, 1'b0);
    checks += 2;
    if (occupancy !== '0) begin failures++; $display("FAIL invalid_occ act=%0d exp=0", occupancy); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL invalid_valid act=%0b exp=0", rd_valid); end
  endtask

  task automatic test_single;
    drive(9'h1A5, 1'b0, 1'b0);
    checks += 3;
    if (rd_valid !== 1'b1)  begin failures++; $display("FAIL single_valid act=%0b exp=1", rd_valid); end
    if (rd_data !== 8'hA5)  begin failures++; $display("FAIL single_data act=%h exp=a5", rd_data); end
    if (occupancy !== 4'd1) begin failures++; $display("FAIL single_occ act=%0d exp=1", occupancy); end
    drive(9'h000, 1'b1, 1'b0);
    checks += 2;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid act=%0b exp=0", rd_valid); end
    if (rd_data !== 8'h00) begin failures++; $display("FAIL single_pop_data act=%h exp=00", rd_data); end
  endtask

  task automatic test_fill;
    int d0;
    d0 = m_drops;
    for (int i = 1; i <= 8; i++) begin
      drive({1'b1, 8'(i)}, 1'b0, 1'b0);
      checks++;
      if (ready_to_mesh !== (i < 6)) begin
        failures++; $display("FAIL fill_ready[%0d] act=%0b exp=%0b", i, ready_to_mesh, (i < 6));
      end
    end
    checks++;
    if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_occ act=%0d exp=8", occupancy); end
    drive(9'h1FF, 1'b0, 1'b0);
    checks += 2;
    if (drop_count !== 8'(d0 + 1)) begin failures++; $display("FAIL fill_drop act=%0d exp=%0d", drop_count, d0 + 1); end
    if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_drop_occ act=%0d exp=8", occupancy); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] act=%h exp=%h", i, rd_data, 8'(i)); end
      drive(9'h000, 1'b1, 1'b0);
    end
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_empty act=%0b exp=0", rd_valid); end
  endtask

  task automatic test_full_pop;
    int d0;
    for (int i = 0; i < 8; i++) drive({1'b1, 8'(8'h30 + i)}, 1'b0, 1'b0);
    d0 = m_drops;
    drive(9'h1EE, 1'b1, 1'b0);
    checks += 3;
    if (drop_count !== 8'(d0 + 1)) begin failures++; $display("FAIL fullpop_drop act=%0d exp=%0d", drop_count, d0 + 1); end
    if (occupancy !== 4'd7) begin failures++; $display("FAIL fullpop_occ act=%0d exp=7", occupancy); end
    if (rd_data !== 8'h31)  begin failures++; $display("FAIL fullpop_head act=%h exp=31", rd_data); end
    repeat (7) drive(9'h000, 1'b1, 1'b0);
  endtask

  task automatic test_stream;
    drive(9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive({1'b1, 8'(i)}, 1'b1, 1'b0);
      checks += 2;
      if (rd_data !== 8'(i)) begin failures++; $display("FAIL stream_data[%0d] act=%h exp=%h", i, rd_data, 8'(i)); end
      if (occupancy > 4'd1)  begin failures++; $display("FAIL stream_occ[%0d] act=%0d exp<=1", i, occupancy); end
    end
    drive(9'h000, 1'b1, 1'b0);
    checks += 2;
    if (drop_count !== 8'h00) begin failures++; $display("FAIL stream_drops act=%0d exp=0", drop_count); end
    if (rd_valid !== 1'b0)    begin failures++; $display("FAIL stream_empty act=%0b exp=0", rd_valid); end
  endtask

  task automatic test_drop_counter;
    for (int i = 0; i < 8; i++) drive({1'b1, 8'(i)}, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) drive({1'b1, 8'($urandom)}, 1'b0, 1'b0);
    checks++;
    if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturate act=%0d exp=255", drop_count); end
    drive(9'h1C3, 1'b0, 1'b1);
    checks++;
    if (drop_count !== 8'h00) begin failures++; $display("FAIL drop_clear act=%0d exp=0", drop_count); end
    repeat (8) drive(9'h000, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [8:0] d;
    logic rdy, clr;
    logic [7:0] exp_data;
    for (int n = 0; n < 600; n++) begin
      d   = {1'($urandom_range(0, 1)), 8'($urandom)};
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 40) == 0);
      drive(d, rdy, clr);
      exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
      checks += 5;
      if (rd_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] act=%0b exp=%0b", n, rd_valid, (mq.size() != 0)); end
      if (rd_data !== exp_data) begin failures++; $display("FAIL rnd_data[%0d] act=%h exp=%h", n, rd_data, exp_data); end
      if (occupancy !== OW'(mq.size())) begin failures++; $display("FAIL rnd_occ[%0d] act=%0d exp=%0d", n, occupancy, mq.size()); end
      if (ready_to_mesh !== (mq.size() < DEPTH - SLACK)) begin failures++; $display("FAIL rnd_ready[%0d] act=%0b exp=%0b", n, ready_to_mesh, (mq.size() < DEPTH - SLACK)); end
      if (drop_count !== 8'(m_drops)) begin failures++; $display("FAIL rnd_drops[%0d] act=%0d exp=%0d", n, drop_count, m_drops); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_full_pop;
    test_stream;
    test_drop_counter;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
